// File: rtl/nco_sweep_ctrl.sv
// Linear step-and-dwell frequency sweep scheduler driving the NCO freq_word/enable.
// Optional NCO_SWEEP_CNT_EN adds sweep_cnt, counting expired endpoint dwells.
module nco_sweep_ctrl #(
  parameter int PHASE_BITS = 20,
  parameter int DWELL_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [PHASE_BITS-1:0] cfg_start_fw,
  input  logic [PHASE_BITS-1:0] cfg_stop_fw,
  input  logic [PHASE_BITS-1:0] cfg_step_fw,
  input  logic [DWELL_BITS-1:0] cfg_dwell,
  input  logic                  cfg_mode,
  input  logic                  abort,
  output logic                  nco_enable,
  output logic [PHASE_BITS-1:0] freq_word,
  output logic                  sweep_active,
`ifdef NCO_SWEEP_CNT_EN
  output logic [15:0]           sweep_cnt,
`endif
  output logic                  sweep_done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                state_q, state_d;
  logic [PHASE_BITS-1:0] freq_q, freq_d;
  logic [PHASE_BITS-1:0] start_q, start_d;
  logic [PHASE_BITS-1:0] stop_q, stop_d;
  logic [PHASE_BITS-1:0] step_q, step_d;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic [DWELL_BITS-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                  mode_q, mode_d;
  logic                  up_q, up_d;
  logic                  to_stop_q, to_stop_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  active_q, active_d;
  logic                  ready_q, ready_d;
  logic [PHASE_BITS-1:0] target;
  logic [PHASE_BITS-1:0] turn_target;
`ifdef NCO_SWEEP_CNT_EN
  logic [15:0]           sweep_cnt_q, sweep_cnt_d;
`endif

  // One step toward tgt in PHASE_BITS+1 bits; reaching or passing tgt (including
  // carry/borrow out of the word) saturates to tgt, so the word never wraps.
  function automatic logic [PHASE_BITS-1:0] step_toward(
    input logic [PHASE_BITS-1:0] cur,
    input logic [PHASE_BITS-1:0] stp,
    input logic [PHASE_BITS-1:0] tgt,
    input logic                  go_up
  );
    logic [PHASE_BITS:0] ext;
    logic [PHASE_BITS-1:0] res;
    if (go_up) begin
      ext = {1'b0, cur} + {1'b0, stp};
      res = (ext >= {1'b0, tgt}) ? tgt : ext[PHASE_BITS-1:0];
    end else begin
      ext = {1'b0, cur} - {1'b0, stp};
      res = (ext[PHASE_BITS] || (ext <= {1'b0, tgt})) ? tgt : ext[PHASE_BITS-1:0];
    end
    return res;
  endfunction

  assign target      = to_stop_q ? stop_q : start_q;
  assign turn_target = to_stop_q ? start_q : stop_q;

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    up_d        = up_q;
    to_stop_d   = to_stop_q;
    en_d        = en_q;
    done_d      = 1'b0;
`ifdef NCO_SWEEP_CNT_EN
    sweep_cnt_d = sweep_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!abort && cfg_valid) begin
          start_d     = cfg_start_fw;
          stop_d      = cfg_stop_fw;
          step_d      = (cfg_step_fw == '0) ? PHASE_BITS'(1) : cfg_step_fw;
          dwell_d     = cfg_dwell;
          mode_d      = cfg_mode;
          up_d        = (cfg_stop_fw >= cfg_start_fw);
          to_stop_d   = 1'b1;
          freq_d      = cfg_start_fw;
          dwell_cnt_d = cfg_dwell;
          en_d        = 1'b1;
          state_d     = DWELL;
`ifdef NCO_SWEEP_CNT_EN
          sweep_cnt_d = '0;
`endif
        end
      end
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end else if (freq_q != target) begin
          freq_d      = step_toward(freq_q, step_q, target, up_q);
          dwell_cnt_d = dwell_q;
        end else begin
`ifdef NCO_SWEEP_CNT_EN
          if (sweep_cnt_q != 16'hFFFF) sweep_cnt_d = sweep_cnt_q + 16'd1;
`endif
          if (!mode_q) begin
            state_d = IDLE;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Turnaround steps immediately so the endpoint is held only one dwell.
            up_d        = ~up_q;
            to_stop_d   = ~to_stop_q;
            freq_d      = step_toward(freq_q, step_q, turn_target, ~up_q);
            dwell_cnt_d = dwell_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
    active_d = (state_d == DWELL);
    ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      freq_q      <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= 1'b0;
      up_q        <= 1'b1;
      to_stop_q   <= 1'b1;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      active_q    <= 1'b0;
      ready_q     <= 1'b1;
`ifdef NCO_SWEEP_CNT_EN
      sweep_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
      up_q        <= up_d;
      to_stop_q   <= to_stop_d;
      en_q        <= en_d;
      done_q      <= done_d;
      active_q    <= active_d;
      ready_q     <= ready_d;
`ifdef NCO_SWEEP_CNT_EN
      sweep_cnt_q <= sweep_cnt_d;
`endif
    end
  end

  assign cfg_ready    = ready_q;
  assign nco_enable   = en_q;
  assign freq_word    = freq_q;
  assign sweep_active = active_q;
  assign sweep_done   = done_q;
`ifdef NCO_SWEEP_CNT_EN
  assign sweep_cnt    = sweep_cnt_q;
`endif

endmodule
